mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single main-memory port between two cache requesters: requester 0 is the data cache (write-through stores and refills), requester 1 is the instruction-cache refill path.
- Owns the memory timing. Main memory has a fixed MEM_LAT-cycle access and no ready signal, so this block counts the cycles itself.
- Serves one access at a time. Requests arriving together are ordered round-robin. The block sits between the cache controllers and main memory at the cache top level.

Parameters:
- ADDR_W, 32, word-address width.
- DATA_W, 32, word width.
- BLOCK_WORDS, 4, words per cache block; must be a power of two.
- MEM_LAT, 4, memory access cycles; must be at least 1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_neg  in  1  asynchronous, active-low reset.
- req0  in  1  requester 0 access request; held until done0.
- we0  in  1  requester 0: 1 = single-word write, 0 = block read.
- addr0  in  ADDR_W  requester 0 word address.
- wdata0  in  DATA_W  requester 0 write data.
- req1, we1, addr1, wdata1  in  1/1/ADDR_W/DATA_W  requester 1, same meanings as requester 0.
- gnt0  out  1  requester 0 owns the port (ACCESS and RESP).
- gnt1  out  1  requester 1 owns the port.
- done0  out  1  one-cycle completion pulse to requester 0.
- done1  out  1  one-cycle completion pulse to requester 1.
- rdata  out  DATA_W*BLOCK_WORDS  block read data; valid while done0 or done1 is high.
- busy  out  1  the arbiter is not IDLE.
- mem_en  out  1  memory enable; high for the whole access.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory word address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W*BLOCK_WORDS  memory block read data; valid in the last ACCESS cycle.

Behaviour:
- Reset:
  - Outputs: gnt0/1=0, done0/1=0, busy=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, rdata=0.
  - Internal: state=IDLE, rr_ptr=0 (requester 0 preferred), cnt=0.
- Reset asserted mid-access: the access is abandoned immediately and no done pulse is issued. The requester must re-request after reset.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - No req: stay in IDLE.
  - One req: grant that requester.
  - Both req: grant the requester selected by rr_ptr.
  - On grant, at the edge: latch owner, we, addr, wdata. Set cnt=MEM_LAT-1 and go to ACCESS.
  - Read address is aligned: the low log2(BLOCK_WORDS) bits are cleared. Write address is passed unmodified.
- ACCESS:
  - mem_en=1. mem_we, mem_addr and mem_wdata come from the latched values and are stable for all MEM_LAT cycles.
  - The owner's gnt is high.
  - cnt decrements each cycle. At the edge where cnt==0: if the access is a read, register mem_rdata into rdata; then go to RESP.
- RESP:
  - mem_en=0. The owner's done is high for exactly one cycle and gnt stays high.
  - For a read, rdata holds the block. For a write, rdata keeps its previous value.
  - rr_ptr is set to the non-owner, then state returns to IDLE.
- Latency: a request sampled in IDLE at edge t gives done high during cycle t+MEM_LAT+1. Requests are back-to-back with one IDLE cycle between accesses.
- Requester handshake:
  - req, we, addr and wdata must be held stable from req assertion until done is sampled.
  - req must drop at the edge at which done is sampled high. A req still high in the following IDLE cycle is a new request.
  - Inputs that change during ACCESS are ignored, because the latched values are used.
- Starvation bound: round-robin order means a waiting requester is served after at most one access by the other requester.
- A requester that is not the owner sees gnt=0 and done=0 throughout.
- A simultaneous new req and RESP cycle is legal. The new req is evaluated in the following IDLE cycle.

Decomposition:
- Shared package cache_pkg:
  - State enum {IDLE, ACCESS, RESP}.
  - Default constants ADDR_W, DATA_W, BLOCK_WORDS, MEM_LAT.
  - Derived constant OFF_W=$clog2(BLOCK_WORDS), used for address alignment.
- One sub-module: rr_arb2. It is a combinational 2-way round-robin pick from req0, req1 and rr_ptr, with a one-hot grant select. The FSM, latches and counter stay in mem_port_arbiter.

Test Plan:
- Reset check: hold reset_neg=0 with req0=1 -> all outputs are 0 and mem_en=0. Release reset -> gnt0 rises at the next edge.
- Single write: req0=1, we0=1, addr0=129, wdata0=2 -> mem_en=1, mem_we=1, mem_addr=129, mem_wdata=2 for exactly 4 cycles. done0 pulses in the 5th cycle after the grant edge, and busy=1 throughout.
- Block read with alignment: req1=1, we1=0, addr1=130, mem_rdata={4,3,2,1} -> mem_addr=128 and mem_we=0. done1 pulses with rdata={4,3,2,1}. done0 stays 0.
- Simultaneous requests: after reset, req0 (write 131, data 4) and req1 (read 128) rise together -> requester 0 is served first. After one IDLE cycle requester 1 is served. A further simultaneous pair is then served in the order 0, 1.
- Round-robin fairness: req0 held continuously (re-requesting) and req1 held -> grants alternate 0, 1, 0, 1. No requester waits more than one access.
- Reset mid-access: reset_neg pulsed low in the 2nd ACCESS cycle -> mem_en drops asynchronously and no done pulse occurs. After release, the held req0 restarts a full 4-cycle access.

Source files
------------

// File: rtl/cache_pkg.sv
`default_nettype none
// ==========================================================================
// cache_pkg : shared types and default sizes for the cache memory port
// Revision  : 1.0
// ==========================================================================
package cache_pkg;

  localparam int ADDR_W      = 32;
  localparam int DATA_W      = 32;
  localparam int BLOCK_WORDS = 4;
  localparam int MEM_LAT     = 4;
  localparam int OFF_W       = $clog2(BLOCK_WORDS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_rr_arb2.sv
`default_nettype none
// ==========================================================================
// rr_arb2 : combinational two-way round-robin pick with one-hot select
// Revision : 1.0
// ==========================================================================
module rr_arb2 (
  input  logic       req0,
  input  logic       req1,
  input  logic       rr_ptr,
  output logic [1:0] gnt_sel
);

  // rr_ptr names the requester preferred when both are asking
  always_comb begin
    gnt_sel = 2'b00;
    if (req0 && req1) begin
      gnt_sel = rr_ptr ? 2'b10 : 2'b01;
    end else if (req0) begin
      gnt_sel = 2'b01;
    end else if (req1) begin
      gnt_sel = 2'b10;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ==========================================================================
// mem_port_arbiter : shares one fixed-latency memory port between D$ and I$
// Revision         : 1.0
// ==========================================================================
module mem_port_arbiter
  import cache_pkg::*;
#(
  parameter int ADDR_W      = cache_pkg::ADDR_W,
  parameter int DATA_W      = cache_pkg::DATA_W,
  parameter int BLOCK_WORDS = cache_pkg::BLOCK_WORDS,
  parameter int MEM_LAT     = cache_pkg::MEM_LAT
) (
  input  logic                          clk,
  input  logic                          reset_neg,
  input  logic                          req0,
  input  logic                          we0,
  input  logic [ADDR_W-1:0]             addr0,
  input  logic [DATA_W-1:0]             wdata0,
  input  logic                          req1,
  input  logic                          we1,
  input  logic [ADDR_W-1:0]             addr1,
  input  logic [DATA_W-1:0]             wdata1,
  output logic                          gnt0,
  output logic                          gnt1,
  output logic                          done0,
  output logic                          done1,
  output logic [DATA_W*BLOCK_WORDS-1:0] rdata,
  output logic                          busy,
  output logic                          mem_en,
  output logic                          mem_we,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  input  logic [DATA_W*BLOCK_WORDS-1:0] mem_rdata
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [ADDR_W-1:0] C_ALIGN_MASK = ~(ADDR_W'(BLOCK_WORDS - 1));

  state_t                        r_state;
  state_t                        w_next;
  logic                          r_owner;
  logic                          r_we;
  logic [ADDR_W-1:0]             r_addr;
  logic [DATA_W-1:0]             r_wdata;
  logic [CNT_W-1:0]              r_cnt;
  logic                          r_rr_ptr;
  logic [DATA_W*BLOCK_WORDS-1:0] r_rdata;

  logic [1:0]                    w_sel;
  logic                          w_grant;
  logic                          w_we;
  logic [ADDR_W-1:0]             w_addr_raw;
  logic [ADDR_W-1:0]             w_addr;
  logic [DATA_W-1:0]             w_wdata;

  rr_arb2 u_rr_arb2 (
    .req0    (req0),
    .req1    (req1),
    .rr_ptr  (r_rr_ptr),
    .gnt_sel (w_sel)
  );

  assign w_grant    = (r_state == IDLE) && (w_sel != 2'b00);
  assign w_we       = w_sel[1] ? we1    : we0;
  assign w_addr_raw = w_sel[1] ? addr1  : addr0;
  assign w_wdata    = w_sel[1] ? wdata1 : wdata0;
  // Block reads fetch the whole aligned block; writes touch one exact word.
  assign w_addr     = w_we ? w_addr_raw : (w_addr_raw & C_ALIGN_MASK);

  always_ff @(posedge clk or negedge reset_neg) begin
    if (!reset_neg) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_grant) w_next = ACCESS;
      ACCESS:  if (r_cnt == '0) w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_neg) begin
    if (!reset_neg) begin
      r_owner  <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_cnt    <= '0;
      r_rr_ptr <= 1'b0;
      r_rdata  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant) begin
            r_owner <= w_sel[1];
            r_we    <= w_we;
            r_addr  <= w_addr;
            r_wdata <= w_wdata;
            r_cnt   <= CNT_W'(MEM_LAT - 1);
          end
        end
        ACCESS: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else if (!r_we) begin
            r_rdata <= mem_rdata;
          end
        end
        RESP: begin
          r_rr_ptr <= ~r_owner;
        end
        default: begin
          r_cnt <= '0;
        end
      endcase
    end
  end

  // Everything seen by memory and requesters decodes straight from state,
  // so an asynchronous reset kills the access in the same instant.
  assign busy      = (r_state != IDLE);
  assign gnt0      = busy && !r_owner;
  assign gnt1      = busy &&  r_owner;
  assign done0     = (r_state == RESP) && !r_owner;
  assign done1     = (r_state == RESP) &&  r_owner;
  assign mem_en    = (r_state == ACCESS);
  assign mem_we    = mem_en && r_we;
  assign mem_addr  = mem_en ? r_addr  : '0;
  assign mem_wdata = mem_en ? r_wdata : '0;
  assign rdata     = r_rdata;

endmodule
`default_nettype wire
